sync_fifo: RTL and testbench
============================

SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 Parameter: DATA_SIZE, 32, payload width in bits.
REQ-002 Parameter: DEPTH, 4, number of entries; power of two, >= 2.
REQ-003 Parameter: AF_MARGIN, 1, almost-full threshold margin; 0 <= AF_MARGIN < DEPTH.
REQ-004 Parameter: FALLTHROUGH, 0, 1 = empty-FIFO bypass from input to output in the same cycle.
REQ-005 Port: clk  input  1  clock; all state updates on rising edge.
REQ-006 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-007 Port: flush_i  input  1  synchronous clear of all entries.
REQ-008 Port: data_i  input  DATA_SIZE  write payload.
REQ-009 Port: valid_i  input  1  producer offers data_i.
REQ-010 Port: ready_o  output  1  FIFO accepts data this cycle.
REQ-011 Port: data_o  output  DATA_SIZE  head payload.
REQ-012 Port: valid_o  output  1  data_o is valid.
REQ-013 Port: ready_i  input  1  consumer takes data_o this cycle.
REQ-014 Port: count_o  output  $clog2(DEPTH+1)  current occupancy.
REQ-015 Port: almost_full_o  output  1  count_o >= DEPTH-AF_MARGIN.

Function
REQ-016 push = valid_i && ready_o; pop = valid_o && ready_i; each transfers exactly one entry.
REQ-017 ready_o SHALL be !full, registered-state only; no combinational path from ready_i or valid_i.
REQ-018 valid_o SHALL be (count != 0), or (FALLTHROUGH && valid_i) when count == 0.
REQ-019 data_o SHALL equal mem[rd_ptr] when count != 0; data_i when FALLTHROUGH and count == 0; undefined (unchecked) when valid_o = 0.
REQ-020 Latency with FALLTHROUGH=0: an entry pushed in cycle N is visible on data_o/valid_o in cycle N+1 at the earliest.
REQ-021 FALLTHROUGH=1, count == 0, valid_i && ready_i: data passes through, nothing stored, count stays 0.
REQ-022 Order SHALL be strictly first-in first-out; no entry dropped or duplicated.
REQ-023 wr_ptr/rd_ptr are $clog2(DEPTH) bits and wrap modulo DEPTH; full/empty SHALL be derived from count, not from pointer equality.
REQ-024 Simultaneous push and pop with 0 < count < DEPTH: count unchanged, both pointers advance.
REQ-025 Full (count == DEPTH): ready_o = 0; a same-cycle pop does not enable a push; push resumes the following cycle.
REQ-026 Empty with FALLTHROUGH=0: valid_o = 0; a same-cycle push is not poppable until the next cycle.
REQ-027 flush_i SHALL set count, wr_ptr and rd_ptr to 0 on the next edge, overriding any same-cycle push or pop.
REQ-028 Producer and consumer are never stalled by handshake violations; behaviour of valid_i deassertion without transfer is legal and ignored.

Reset
REQ-029 When rst_n = 0 at a rising edge: count_o = 0, pointers = 0; hence valid_o = 0 (FALLTHROUGH=0), ready_o = 1, almost_full_o = 0 after that edge.
REQ-030 Reset mid-operation SHALL discard all entries; storage array is not reset.
REQ-031 Reset has priority over flush_i, push and pop.

Structure
REQ-032 No shared package types needed; occupancy width is a localparam derived from DEPTH.
REQ-033 Storage SHALL be one sub-module, fifo_mem (DATA_SIZE x DEPTH, 1 write port, 1 async read port, no reset); pointers, count and handshake logic stay in sync_fifo.

Verification (DATA_SIZE=32, DEPTH=4, AF_MARGIN=1 unless stated)
REQ-034 Push 0xA0..0xA3 with ready_i = 0 -> count_o 1,2,3,4; almost_full_o rises at count 3; ready_o = 0 at count 4; fifth push 0xA4 refused.
REQ-035 From full, ready_i = 1 for 4 cycles -> data_o 0xA0,0xA1,0xA2,0xA3 in order, then valid_o = 0, count_o = 0.
REQ-036 Count 2, push and pop every cycle for 10 cycles -> count_o stays 2, pointers wrap, output sequence matches input order.
REQ-037 Count 3, flush_i = 1 with valid_i = 1 same cycle -> next cycle count_o = 0, valid_o = 0, pushed word not stored.
REQ-038 FALLTHROUGH=1, empty, valid_i = 1 data_i = 0x5A, ready_i = 1 -> same cycle valid_o = 1, data_o = 0x5A; next cycle count_o = 0.
REQ-039 Count 3, rst_n = 0 for one edge -> count_o = 0, valid_o = 0, ready_o = 1; subsequent push 0x11 read back as 0x11.

Source files
------------

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - FIFO storage array: one write port, one asynchronous read port
//
// Parameters:
//   DATA_SIZE  entry width in bits
//   DEPTH      number of entries (power of two)
// Ports:
//   clk      clock; writes land on the rising edge
//   we_i     write enable
//   waddr_i  write address
//   wdata_i  write payload
//   raddr_i  read address
//   rdata_o  combinational read data
//
// The array has no reset. Occupancy bookkeeping in the parent decides which
// entries are meaningful.

module fifo_mem #(
    parameter int unsigned DATA_SIZE = 32,
    parameter int unsigned DEPTH     = 4,
    localparam int unsigned ADDR_W   = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 we_i,
    input  logic [ADDR_W-1:0]    waddr_i,
    input  logic [DATA_SIZE-1:0] wdata_i,
    input  logic [ADDR_W-1:0]    raddr_i,
    output logic [DATA_SIZE-1:0] rdata_o
);

    logic [DATA_SIZE-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - Synchronous valid/ready FIFO with optional empty bypass
//
// Parameters:
//   DATA_SIZE    payload width in bits
//   DEPTH        number of entries (power of two, >= 2)
//   AF_MARGIN    almost_full_o asserts at count >= DEPTH - AF_MARGIN
//   FALLTHROUGH  1 = an empty FIFO passes data_i straight to data_o
// Ports:
//   clk            clock
//   rst_n          synchronous active-low reset
//   flush_i        synchronous clear of all entries
//   data_i         write payload
//   valid_i        producer offers data_i
//   ready_o        FIFO accepts data this cycle (registered state only)
//   data_o         head payload
//   valid_o        data_o is valid
//   ready_i        consumer takes data_o this cycle
//   count_o        current occupancy
//   almost_full_o  occupancy at or above the almost-full threshold

module sync_fifo #(
    parameter int unsigned DATA_SIZE   = 32,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned AF_MARGIN   = 1,
    parameter bit          FALLTHROUGH = 1'b0,
    localparam int unsigned CNT_W      = $clog2(DEPTH + 1),
    localparam int unsigned PTR_W      = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush_i,
    input  logic [DATA_SIZE-1:0] data_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    output logic [DATA_SIZE-1:0] data_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [CNT_W-1:0]     count_o,
    output logic                 almost_full_o
);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_AF   = CNT_W'(DEPTH - AF_MARGIN);

    logic [CNT_W-1:0]     count_q, count_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [DATA_SIZE-1:0] rd_data;

    logic full;
    logic empty;
    logic bypass;
    logic push;
    logic pop;
    logic pass_through;
    logic do_write;
    logic do_read;

    // Full/empty come from the occupancy counter, never from pointer compare,
    // so ready_o depends on registered state only.
    assign full  = (count_q == CNT_FULL);
    assign empty = (count_q == '0);

    // Bypass offers data_i on the output while nothing is stored.
    assign bypass = FALLTHROUGH && empty && valid_i;

    assign ready_o       = !full;
    assign valid_o       = !empty || bypass;
    assign data_o        = (FALLTHROUGH && empty) ? data_i : rd_data;
    assign count_o       = count_q;
    assign almost_full_o = (count_q >= CNT_AF);

    assign push = valid_i && ready_o;
    assign pop  = valid_o && ready_i;

    // A bypassed word consumed in the same cycle never touches storage.
    assign pass_through = bypass && ready_i;
    assign do_write     = push && !pass_through;
    assign do_read      = pop && !empty;

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_write) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (do_read) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({do_write, do_read})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    fifo_mem #(
        .DATA_SIZE (DATA_SIZE),
        .DEPTH     (DEPTH)
    ) u_mem (
        .clk     (clk),
        .we_i    (do_write),
        .waddr_i (wr_ptr_q),
        .wdata_i (data_i),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_data)
    );

endmodule

// File: tb/tb_sync_fifo.sv
// tb/tb_sync_fifo.sv - Self-checking bench for sync_fifo (registered and fall-through variants)

module tb_sync_fifo;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic [31:0] data_in;
    logic        valid_in;
    logic        ready_in;

    logic        ready0, valid0, af0;
    logic [31:0] data0;
    logic [2:0]  count0;
    logic        ready1, valid1, af1;
    logic [31:0] data1;
    logic [2:0]  count1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sync_fifo #(.DATA_SIZE(32), .DEPTH(4), .AF_MARGIN(1), .FALLTHROUGH(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .flush_i(flush), .data_i(data_in), .valid_i(valid_in),
        .ready_o(ready0), .data_o(data0), .valid_o(valid0), .ready_i(ready_in),
        .count_o(count0), .almost_full_o(af0)
    );

    sync_fifo #(.DATA_SIZE(32), .DEPTH(4), .AF_MARGIN(1), .FALLTHROUGH(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .flush_i(flush), .data_i(data_in), .valid_i(valid_in),
        .ready_o(ready1), .data_o(data1), .valid_o(valid1), .ready_i(ready_in),
        .count_o(count1), .almost_full_o(af1)
    );

    typedef struct {
        bit          rst_n;
        bit          flush;
        bit          valid;
        logic [31:0] data;
        bit          rdy;
        bit          chk;
        bit          e_ready;
        bit          e_valid;
        logic [31:0] e_data;
        int          e_count;
        bit          e_af;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit r, bit f, bit v, logic [31:0] d, bit rd, bit c,
                                bit er, bit ev, logic [31:0] ed, int ec, bit ea);
        vec_t t;
        t.rst_n = r; t.flush = f; t.valid = v; t.data = d; t.rdy = rd; t.chk = c;
        t.e_ready = er; t.e_valid = ev; t.e_data = ed; t.e_count = ec; t.e_af = ea;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit r, input bit f, input bit v, input logic [31:0] d, input bit rd);
        rst_n = r; flush = f; valid_in = v; data_in = d; ready_in = rd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
    endtask

    logic [31:0] q0[$];
    logic [31:0] q1[$];

    initial begin
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();

        // Fill / drain / flush / reset scenario on the registered variant.
        tbl.push_back(mk(0,0,0,32'h00,0, 0, 0,0,32'h00,0,0));
        tbl.push_back(mk(1,0,0,32'h00,0, 1, 1,0,32'h00,0,0));
        tbl.push_back(mk(1,0,1,32'hA0,0, 1, 1,0,32'h00,0,0));
        tbl.push_back(mk(1,0,1,32'hA1,0, 1, 1,1,32'hA0,1,0));
        tbl.push_back(mk(1,0,1,32'hA2,0, 1, 1,1,32'hA0,2,0));
        tbl.push_back(mk(1,0,1,32'hA3,0, 1, 1,1,32'hA0,3,1));
        tbl.push_back(mk(1,0,1,32'hA4,0, 1, 0,1,32'hA0,4,1));
        tbl.push_back(mk(1,0,0,32'h00,0, 1, 0,1,32'hA0,4,1));
        tbl.push_back(mk(1,0,1,32'hA5,1, 1, 0,1,32'hA0,4,1));
        tbl.push_back(mk(1,0,0,32'h00,1, 1, 1,1,32'hA1,3,1));
        tbl.push_back(mk(1,0,0,32'h00,1, 1, 1,1,32'hA2,2,0));
        tbl.push_back(mk(1,0,0,32'h00,1, 1, 1,1,32'hA3,1,0));
        tbl.push_back(mk(1,0,0,32'h00,0, 1, 1,0,32'h00,0,0));
        tbl.push_back(mk(1,0,1,32'hB0,0, 1, 1,0,32'h00,0,0));
        tbl.push_back(mk(1,0,1,32'hB1,0, 1, 1,1,32'hB0,1,0));
        tbl.push_back(mk(1,0,1,32'hB2,0, 1, 1,1,32'hB0,2,0));
        tbl.push_back(mk(1,1,1,32'hB3,0, 1, 1,1,32'hB0,3,1));
        tbl.push_back(mk(1,0,0,32'h00,0, 1, 1,0,32'h00,0,0));
        tbl.push_back(mk(1,0,1,32'hC0,0, 1, 1,0,32'h00,0,0));
        tbl.push_back(mk(1,0,1,32'hC1,0, 1, 1,1,32'hC0,1,0));
        tbl.push_back(mk(1,0,1,32'hC2,0, 1, 1,1,32'hC0,2,0));
        tbl.push_back(mk(0,0,0,32'h00,0, 1, 1,1,32'hC0,3,1));
        tbl.push_back(mk(1,0,1,32'h11,0, 1, 1,0,32'h00,0,0));
        tbl.push_back(mk(1,0,0,32'h00,1, 1, 1,1,32'h11,1,0));
        tbl.push_back(mk(1,0,0,32'h00,0, 1, 1,0,32'h00,0,0));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst_n, tbl[i].flush, tbl[i].valid, tbl[i].data, tbl[i].rdy);
            #2;
            if (tbl[i].chk) begin
                chk($sformatf("tbl%0d_ready", i), {31'b0, ready0}, {31'b0, tbl[i].e_ready});
                chk($sformatf("tbl%0d_valid", i), {31'b0, valid0}, {31'b0, tbl[i].e_valid});
                chk($sformatf("tbl%0d_count", i), {29'b0, count0}, tbl[i].e_count);
                chk($sformatf("tbl%0d_af", i), {31'b0, af0}, {31'b0, tbl[i].e_af});
                if (tbl[i].e_valid) begin
                    chk($sformatf("tbl%0d_data", i), data0, tbl[i].e_data);
                end
            end
            tick();
        end

        // Steady push+pop at occupancy 2: count holds, pointers wrap, order kept.
        do_reset();
        drive(1'b1, 1'b0, 1'b1, 32'hD0, 1'b0); tick();
        drive(1'b1, 1'b0, 1'b1, 32'hD1, 1'b0); tick();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b0, 1'b1, 32'hD2 + i, 1'b1);
            #2;
            chk($sformatf("wrap%0d_count", i), {29'b0, count0}, 32'd2);
            chk($sformatf("wrap%0d_data", i), data0, 32'hD0 + i);
            tick();
        end
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        #2;
        chk("wrap_end_count", {29'b0, count0}, 32'd2);
        chk("wrap_end_data", data0, 32'hDA);

        // Fall-through on an empty FIFO: same-cycle bypass, nothing stored.
        do_reset();
        drive(1'b1, 1'b0, 1'b1, 32'h5A, 1'b1);
        #2;
        chk("ft_valid", {31'b0, valid1}, 32'd1);
        chk("ft_data", data1, 32'h5A);
        chk("ft_ready", {31'b0, ready1}, 32'd1);
        chk("noft_valid", {31'b0, valid0}, 32'd0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        #2;
        chk("ft_count_after", {29'b0, count1}, 32'd0);
        chk("ft_valid_after", {31'b0, valid1}, 32'd0);
        chk("noft_count_after", {29'b0, count0}, 32'd1);
        tick();

        // Randomized traffic against a queue model for both variants.
        do_reset();
        q0.delete();
        q1.delete();
        for (int cyc = 0; cyc < 600; cyc++) begin
            bit          r, f, v, rd;
            logic [31:0] d;
            int          s0, s1;
            bit          ev1, push0, pop0, push1, pop1, thru;
            r  = ($urandom_range(63) != 0);
            f  = ($urandom_range(31) == 0);
            v  = (cyc % 200 < 100) ? ($urandom_range(3) != 0) : ($urandom_range(3) == 0);
            rd = (cyc % 200 < 100) ? ($urandom_range(3) == 0) : ($urandom_range(3) != 0);
            d  = $urandom;
            drive(r, f, v, d, rd);
            #2;
            s0  = q0.size();
            s1  = q1.size();
            ev1 = (s1 > 0) || v;
            chk($sformatf("rnd%0d_ready0", cyc), {31'b0, ready0}, {31'b0, s0 < 4});
            chk($sformatf("rnd%0d_valid0", cyc), {31'b0, valid0}, {31'b0, s0 > 0});
            chk($sformatf("rnd%0d_count0", cyc), {29'b0, count0}, s0);
            chk($sformatf("rnd%0d_af0", cyc), {31'b0, af0}, {31'b0, s0 >= 3});
            if (s0 > 0) chk($sformatf("rnd%0d_data0", cyc), data0, q0[0]);
            chk($sformatf("rnd%0d_ready1", cyc), {31'b0, ready1}, {31'b0, s1 < 4});
            chk($sformatf("rnd%0d_valid1", cyc), {31'b0, valid1}, {31'b0, ev1});
            chk($sformatf("rnd%0d_count1", cyc), {29'b0, count1}, s1);
            chk($sformatf("rnd%0d_af1", cyc), {31'b0, af1}, {31'b0, s1 >= 3});
            if (ev1) chk($sformatf("rnd%0d_data1", cyc), data1, (s1 > 0) ? q1[0] : d);
            tick();
            if (!r || f) begin
                q0.delete();
                q1.delete();
            end else begin
                push0 = v && (s0 < 4);
                pop0  = (s0 > 0) && rd;
                if (pop0) void'(q0.pop_front());
                if (push0) q0.push_back(d);
                push1 = v && (s1 < 4);
                pop1  = ev1 && rd;
                thru  = (s1 == 0) && v && rd;
                if (pop1 && s1 > 0) void'(q1.pop_front());
                if (push1 && !thru) q1.push_back(d);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
